// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and sequencer for the single-port data memory.
// Port 0 is the core load/store path, port 1 is the debug/DMA loader.
module dmem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              dm_read,
  output logic              dm_write,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              grant
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES - 1);

  state_t            state;
  state_t            state_n;
  logic              prio;
  logic              prio_n;
  logic              grant_q;
  logic              grant_n;
  logic [3:0]        cnt;
  logic [3:0]        cnt_n;
  logic              load;
  logic              cap;
  logic              sel;
  logic              we_l;
  logic [ADDR_W-1:0] addr_l;
  logic [DATA_W-1:0] wdata_l;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;

  // Contention goes to prio; a lone requester always wins.
  assign sel = (m0_req && m1_req) ? prio : m1_req;

  // Control state and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      prio    <= 1'b0;
      grant_q <= 1'b0;
      cnt     <= 4'd0;
    end else begin
      state   <= state_n;
      prio    <= prio_n;
      grant_q <= grant_n;
      cnt     <= cnt_n;
    end
  end

  // Next-state, pointer update, command latch and read-capture strobes.
  always_comb begin
    state_n = state;
    prio_n  = prio;
    grant_n = grant_q;
    cnt_n   = cnt;
    load    = 1'b0;
    cap     = 1'b0;
    unique case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          grant_n = sel;
          prio_n  = ~sel;
          cnt_n   = WAIT_INIT;
          load    = 1'b1;
          state_n = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt == 4'd0) begin
          cap     = ~we_l;
          state_n = RESP;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      RESP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Latch the granted port's command for the whole access.
  always_ff @(posedge clk) begin
    if (reset) begin
      we_l    <= 1'b0;
      addr_l  <= '0;
      wdata_l <= '0;
    end else if (load) begin
      we_l    <= sel ? m1_we    : m0_we;
      addr_l  <= sel ? m1_addr  : m0_addr;
      wdata_l <= sel ? m1_wdata : m0_wdata;
    end
  end

  // Per-port read data, updated only by that port's completed reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else if (cap) begin
      if (grant_q) begin
        rdata1_q <= rdata;
      end else begin
        rdata0_q <= rdata;
      end
    end
  end

  // Memory command is live only in ACCESS; everything else idles at 0.
  always_comb begin
    dm_read  = 1'b0;
    dm_write = 1'b0;
    addr     = '0;
    wdata    = '0;
    if (state == ACCESS) begin
      dm_read  = ~we_l;
      dm_write = we_l;
      addr     = addr_l;
      wdata    = wdata_l;
    end
  end

  assign m0_ack   = (state == RESP) && !grant_q;
  assign m1_ack   = (state == RESP) && grant_q;
  assign m0_rdata = rdata0_q;
  assign m1_rdata = rdata1_q;
  assign busy     = (state != IDLE);
  assign grant    = grant_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter.
// Instance a uses WAIT_CYCLES=1 with a memory model, b uses WAIT_CYCLES=3.
module tb_dmem_arbiter;

  logic        clk;
  logic        reset;

  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ack, m1_ack;
  logic [31:0] m0_rdata, m1_rdata;
  logic        dm_read, dm_write;
  logic [31:0] addr, wdata, rdata;
  logic        busy, grant;

  logic        b_req, b_we, b_m1_req, b_m1_we;
  logic [31:0] b_addr_in, b_wdata_in, b_m1_addr, b_m1_wdata;
  logic        b_ack, b_m1_ack;
  logic [31:0] b_rdata_out, b_m1_rdata;
  logic        b_dm_read, b_dm_write;
  logic [31:0] b_addr, b_wdata, b_rdata;
  logic        b_busy, b_grant;

  logic [31:0] mem [0:15];

  int checks;
  int failures;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1)) u_a (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .dm_read(dm_read), .dm_write(dm_write), .addr(addr),
    .wdata(wdata), .rdata(rdata), .busy(busy), .grant(grant)
  );

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(3)) u_b (
    .clk(clk), .reset(reset),
    .m0_req(b_req), .m0_we(b_we), .m0_addr(b_addr_in),
    .m0_wdata(b_wdata_in), .m0_ack(b_ack), .m0_rdata(b_rdata_out),
    .m1_req(b_m1_req), .m1_we(b_m1_we), .m1_addr(b_m1_addr),
    .m1_wdata(b_m1_wdata), .m1_ack(b_m1_ack), .m1_rdata(b_m1_rdata),
    .dm_read(b_dm_read), .dm_write(b_dm_write), .addr(b_addr),
    .wdata(b_wdata), .rdata(b_rdata), .busy(b_busy), .grant(b_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rdata   = mem[addr[3:0]];
  assign b_rdata = b_addr * 32'd10;

  always @(posedge clk) begin
    if (dm_write) mem[addr[3:0]] <= wdata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'd1; m0_wdata = '0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'd2; m1_wdata = '0;
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({busy, grant, m0_ack, m1_ack, dm_read, dm_write} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=000000",
               {busy, grant, m0_ack, m1_ack, dm_read, dm_write});
    end
    checks++;
    if (addr !== 32'd0 || wdata !== 32'd0) begin
      failures++;
      $display("FAIL reset_bus addr=%h wdata=%h exp=0", addr, wdata);
    end
    checks++;
    if (m0_rdata !== 32'd0 || m1_rdata !== 32'd0) begin
      failures++;
      $display("FAIL reset_rdata m0=%h m1=%h exp=0", m0_rdata, m1_rdata);
    end
    reset = 1'b0;
  endtask

  task automatic test_simultaneous();
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (grant !== k[0] || busy !== 1'b1 || dm_read !== 1'b1) begin
        failures++;
        $display("FAIL rr_grant%0d grant=%b busy=%b rd=%b exp=%b 1 1",
                 k, grant, busy, dm_read, k[0]);
      end
      checks++;
      if (addr !== (k[0] ? 32'd2 : 32'd1)) begin
        failures++;
        $display("FAIL rr_addr%0d got=%0d exp=%0d",
                 k, addr, k[0] ? 2 : 1);
      end
      tick();
      checks++;
      if (m0_ack !== ~k[0] || m1_ack !== k[0]) begin
        failures++;
        $display("FAIL rr_ack%0d m0=%b m1=%b exp=%b %b",
                 k, m0_ack, m1_ack, ~k[0], k[0]);
      end
      checks++;
      if (k[0] ? (m1_rdata !== 32'd20) : (m0_rdata !== 32'd10)) begin
        failures++;
        $display("FAIL rr_rdata%0d m0=%0d m1=%0d exp=%0d",
                 k, m0_rdata, m1_rdata, k[0] ? 20 : 10);
      end
      tick();
      checks++;
      if (busy !== 1'b0) begin
        failures++;
        $display("FAIL rr_idle%0d busy=%b exp=0", k, busy);
      end
      if (k == 3) begin
        m0_req = 1'b0;
        m1_req = 1'b0;
      end
    end
    tick();
  endtask

  task automatic test_single_read();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'd5;
    tick();
    checks++;
    if (dm_read !== 1'b1 || dm_write !== 1'b0 || addr !== 32'd5) begin
      failures++;
      $display("FAIL sr_cmd rd=%b wr=%b addr=%0d exp=1 0 5",
               dm_read, dm_write, addr);
    end
    tick();
    checks++;
    if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin
      failures++;
      $display("FAIL sr_ack m0=%b m1=%b exp=1 0", m0_ack, m1_ack);
    end
    checks++;
    if (m0_rdata !== 32'd50) begin
      failures++;
      $display("FAIL sr_rdata got=%0d exp=50", m0_rdata);
    end
    m0_req = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || m0_ack !== 1'b0 || m1_ack !== 1'b0) begin
      failures++;
      $display("FAIL sr_after busy=%b m0=%b m1=%b exp=0 0 0",
               busy, m0_ack, m1_ack);
    end
  endtask

  task automatic test_write_then_read();
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'd7; m1_wdata = 32'hDEADBEEF;
    tick();
    checks++;
    if (dm_write !== 1'b1 || dm_read !== 1'b0 || grant !== 1'b1) begin
      failures++;
      $display("FAIL wr_cmd wr=%b rd=%b grant=%b exp=1 0 1",
               dm_write, dm_read, grant);
    end
    checks++;
    if (addr !== 32'd7 || wdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL wr_bus addr=%0d wdata=%h exp=7 deadbeef", addr, wdata);
    end
    tick();
    checks++;
    if (m1_ack !== 1'b1 || dm_write !== 1'b0 || m1_rdata !== 32'd20) begin
      failures++;
      $display("FAIL wr_ack ack=%b wr=%b m1_rdata=%0d exp=1 0 20",
               m1_ack, dm_write, m1_rdata);
    end
    checks++;
    if (mem[7] !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL wr_mem got=%h exp=deadbeef", mem[7]);
    end
    m1_we = 1'b0;
    tick();
    tick();
    checks++;
    if (dm_read !== 1'b1 || addr !== 32'd7) begin
      failures++;
      $display("FAIL rd7_cmd rd=%b addr=%0d exp=1 7", dm_read, addr);
    end
    tick();
    checks++;
    if (m1_ack !== 1'b1 || m1_rdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL rd7_data ack=%b got=%h exp=1 deadbeef", m1_ack, m1_rdata);
    end
    checks++;
    if (m0_rdata !== 32'd50) begin
      failures++;
      $display("FAIL rd7_m0_keep got=%0d exp=50", m0_rdata);
    end
    m1_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    int acks_seen;
    acks_seen = 0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'd3;
    tick();
    checks++;
    if (busy !== 1'b1 || dm_read !== 1'b1) begin
      failures++;
      $display("FAIL rm_access busy=%b rd=%b exp=1 1", busy, dm_read);
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({busy, grant, m0_ack, m1_ack, dm_read, dm_write} !== 6'b0 ||
        addr !== 32'd0 || m0_rdata !== 32'd0) begin
      failures++;
      $display("FAIL rm_idle ctl=%b addr=%h m0_rdata=%h exp=0",
               {busy, grant, m0_ack, m1_ack, dm_read, dm_write},
               addr, m0_rdata);
    end
    reset = 1'b0;
    m0_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (m0_ack) acks_seen++;
      tick();
    end
    checks++;
    if (acks_seen != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rm_noack acks=%0d busy=%b exp=0 0", acks_seen, busy);
    end
  endtask

  task automatic test_extended_wait();
    b_req = 1'b1; b_we = 1'b0; b_addr_in = 32'd9;
    for (int c = 1; c <= 3; c++) begin
      tick();
      checks++;
      if (b_dm_read !== 1'b1 || b_busy !== 1'b1 || b_ack !== 1'b0 ||
          b_addr !== 32'd9) begin
        failures++;
        $display("FAIL ew_access%0d rd=%b busy=%b ack=%b addr=%0d exp=1 1 0 9",
                 c, b_dm_read, b_busy, b_ack, b_addr);
      end
    end
    tick();
    checks++;
    if (b_ack !== 1'b1 || b_busy !== 1'b1 || b_dm_read !== 1'b0) begin
      failures++;
      $display("FAIL ew_ack ack=%b busy=%b rd=%b exp=1 1 0",
               b_ack, b_busy, b_dm_read);
    end
    checks++;
    if (b_rdata_out !== 32'd90) begin
      failures++;
      $display("FAIL ew_rdata got=%0d exp=90", b_rdata_out);
    end
    b_req = 1'b0;
    tick();
    checks++;
    if (b_busy !== 1'b0 || b_ack !== 1'b0) begin
      failures++;
      $display("FAIL ew_idle busy=%b ack=%b exp=0 0", b_busy, b_ack);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr_in = '0; b_wdata_in = '0;
    b_m1_req = 1'b0; b_m1_we = 1'b0; b_m1_addr = '0; b_m1_wdata = '0;
    for (int i = 0; i < 16; i++) mem[i] = 32'(i * 10);
    test_reset();
    test_simultaneous();
    test_single_read();
    test_write_then_read();
    test_reset_mid();
    test_extended_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
